// File: rtl/ym_ch_mix.sv
// ym_ch_mix: per-channel operator accumulator with committed hold registers, a DAC override on channel DAC_CH, a round-robin offset-binary output sequencer and an optional YM_CH_MIX_LADDER_EN crossover offset
module ym_ch_mix #(
   parameter int CH_COUNT = 6,
   parameter int OP_W = 9,
   parameter int DAC_CH = CH_COUNT - 1,
   parameter int LADDER_OFS = 4,
   localparam int CH_W = $clog2(CH_COUNT)
) (
   input  logic            MCLK,
   input  logic            IC,
   input  logic            slot_en,
   input  logic [CH_W-1:0] ch_idx,
   input  logic [OP_W-1:0] op_value,
   input  logic            op_valid,
   input  logic            op_first,
   input  logic            op_last,
   input  logic            dac_en,
   input  logic [7:0]      dac_value,
   input  logic            dac_lsb,
   input  logic            out_tick,
   input  logic            sat_clr,
   output logic [OP_W-1:0] ch_out,
   output logic [CH_W-1:0] ch_out_idx,
   output logic            ch_out_valid,
   output logic            sat_flag
);
   localparam logic signed [OP_W-1:0] s_max = {1'b0, {(OP_W-1){1'b1}}};
   localparam logic signed [OP_W-1:0] s_min = {1'b1, {(OP_W-1){1'b0}}};
   logic signed [OP_W-1:0] acc [CH_COUNT];
   logic signed [OP_W-1:0] hold [CH_COUNT];
   logic [CH_W-1:0] ptr;
   logic hit, ovf;
   logic signed [OP_W-1:0] base, nxt, samp, lad, dac_word;
   logic signed [OP_W:0] sum;
   assign dac_word = OP_W'({~dac_value[7], dac_value[6:0], dac_lsb, {OP_W{1'b0}}} >> 9);
   always_comb begin
      hit = slot_en && ({1'b0, ch_idx} < (CH_W+1)'(CH_COUNT));
      base = (op_first || !hit) ? '0 : acc[ch_idx];
      sum = base + $signed(op_value);
      ovf = op_valid && (sum[OP_W] != sum[OP_W-1]);
      nxt = !op_valid ? base : ovf ? (sum[OP_W] ? s_min : s_max) : sum[OP_W-1:0];
      samp = (dac_en && ptr == CH_W'(DAC_CH)) ? dac_word : hold[ptr];
   end
`ifdef YM_CH_MIX_LADDER_EN
   logic signed [OP_W:0] lad_w;
   assign lad_w = samp[OP_W-1] ? samp - $signed((OP_W+1)'(LADDER_OFS)) : samp + $signed((OP_W+1)'(LADDER_OFS));
   assign lad = (lad_w[OP_W] != lad_w[OP_W-1]) ? (lad_w[OP_W] ? s_min : s_max) : lad_w[OP_W-1:0];
`else
   logic unused_ofs;
   assign unused_ofs = |LADDER_OFS;
   assign lad = samp;
`endif
   always_ff @(posedge MCLK) begin
      if (!IC) begin
         for (int k = 0; k < CH_COUNT; k++) begin
            acc[k] <= '0;
            hold[k] <= '0;
         end
         ptr <= '0;
         ch_out <= {1'b1, {(OP_W-1){1'b0}}};
         ch_out_idx <= '0;
         ch_out_valid <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         if (hit) begin
            acc[ch_idx] <= nxt;
            if (op_last) hold[ch_idx] <= nxt;
         end
         sat_flag <= (hit && ovf) || (sat_flag && !sat_clr);
         ch_out_valid <= out_tick;
         if (out_tick) begin
            ch_out <= {~lad[OP_W-1], lad[OP_W-2:0]};
            ch_out_idx <= ptr;
            ptr <= (ptr == CH_W'(CH_COUNT-1)) ? '0 : ptr + 1'b1;
         end
      end
   end
endmodule
